demod_2ask_bpsk: RTL
====================

// Module: demod_2ask_bpsk
// PURPOSE
//  Receive-side counterpart of the 2ASK/BPSK/2DPSK modulator: coherent integrate-and-dump demodulator.
//  Mixes AD samples with the local NCO cosine, integrates over one symbol, slices one bit per symbol.
//  Sits between the dual-AD capture block and downstream bit sinks (LED, framer, BER counter).
// PARAMETERS
//  AD_W      12   AD sample width, offset-binary unsigned
//  CAR_W     14   NCO cosine width, two's complement
//  SYM_LEN   500  valid samples per symbol (50 MHz / 100 kbaud)
//  ACC_W     36   accumulator width; elaboration error if ACC_W < AD_W+CAR_W+clog2(SYM_LEN)
// PORTS
//  clk         in   1      system clock, 50 MHz
//  rst         in   1      synchronous reset, active-high
//  en          in   1      demodulator enable
//  mode        in   2      0=2ASK, 1=BPSK, 2=2DPSK, 3=reserved (treated as BPSK)
//  ask_thresh  in   ACC_W  unsigned 2ASK decision threshold on |corr|
//  sym_sync    in   1      1-cycle pulse: current sample is sample 0 of a new symbol
//  ad_valid    in   1      ad_in qualifier
//  ad_in       in   AD_W   raw AD sample, offset binary
//  car_cos     in   CAR_W  local carrier, signed, same phase as modulator carrier
//  bit_out     out  1      sliced bit, valid when bit_valid
//  bit_valid   out  1      1-cycle strobe per completed symbol
//  corr_out    out  ACC_W  signed integrated correlation of that symbol
//  busy        out  1      high while a symbol is being integrated
// BEHAVIOUR
//  Reset: bit_out=0, bit_valid=0, corr_out=0, busy=0, accumulator=0, sample count=0, DPSK ref=0, state IDLE.
//  Sample conversion: s = {~ad_in[AD_W-1], ad_in[AD_W-2:0]} (signed); product p = s*car_cos, full width.
//  Pipeline: P1 register p + first/last tags; P2 accumulate (first tag loads acc=p, else acc+=p);
//   P3 registers decision. Last sample presented in cycle N -> bit_valid=1 in cycle N+3.
//  Samples with ad_valid=0 are ignored (count and acc hold); SYM_LEN counts valid samples only.
//  FSM:
//   IDLE: busy=0; en=1 and sym_sync=1 with ad_valid=1 -> INTEG (that sample = sample 0).
//   INTEG: count 0..SYM_LEN-1; valid sample at count SYM_LEN-1 tagged last, count wraps to 0, stays INTEG
//    (back-to-back symbols, no dead cycle); en=0 -> IDLE, in-flight partial symbol discarded.
//  Decision at dump (mode latched at sample 0; mid-symbol mode change applies next symbol):
//   2ASK: bit=1 iff |corr| > ask_thresh (strict).  BPSK: bit=1 iff corr<0 (inverted carrier = 1).
//   2DPSK: b=(corr<0); bit=b^ref; ref<=b after each dump.
//  corr_out updated with bit_out on the same edge; both hold until next dump.
//  sym_sync while INTEG and count!=0: partial symbol dropped (its tags cleared in-flight, no bit_valid),
//   current sample becomes sample 0; DPSK ref cleared to 0.
//  sym_sync coinciding with last-sample slot: sync wins, no bit_valid for that symbol.
//  sym_sync with ad_valid=0: realignment armed, first following valid sample is sample 0.
//  |corr| of most-negative value: computed in ACC_W+1 bits, no wrap.
//  rst mid-symbol: all pipeline stages flushed, no bit_valid emitted after rst released.
// STRUCTURE
//  Package demod_pkg: MODE_ASK/MODE_BPSK/MODE_DPSK encodings, FSM state enum, clog2 function,
//   product width constant.
//  Sub-module mac_int_dump: P1/P2 multiply-accumulate with first/last/drop tags, outputs acc + dump strobe.
//  Top: FSM, sample counter, sync arming, slicer, DPSK reference register.
// TESTING
//  BPSK, SYM_LEN=500, ad from modulator model, bits 1,0,1,1 -> bit_out 1,0,1,1; strobes 500 cycles apart.
//  2ASK, ask_thresh=half on-level corr, carrier off/on/off -> 0,1,0; corr_out of off symbol near 0.
//  2DPSK, phases 0,pi,pi,0 -> bits b0^0, then 1,0,1; sym_sync mid-stream -> ref resets, next bit = b.
//  sym_sync at count 250 -> no bit_valid for truncated symbol; next strobe 500 valid samples after sync.
//  ad_valid 50% duty -> symbol spans 1000 cycles; bit_valid exactly N+3 after 500th valid sample.
//  rst asserted at count 499 -> bit_valid never pulses; all outputs 0 next cycle.

Source files
------------

// File: rtl/demod_2ask_bpsk_pkg.sv
// Shared encodings, FSM states and width helpers for the coherent 2ASK/BPSK/2DPSK demodulator.
package demod_pkg;

    localparam logic [1:0] MODE_ASK  = 2'd0;
    localparam logic [1:0] MODE_BPSK = 2'd1;
    localparam logic [1:0] MODE_DPSK = 2'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_INTEG = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int x = value - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    function automatic int prod_width(input int ad_w, input int car_w);
        return ad_w + car_w;
    endfunction

endpackage

// File: rtl/demod_2ask_bpsk_if.sv
// Sample/control inputs and decision outputs of the demodulator, bundled for the capture side and bit sinks.
interface demod_2ask_bpsk_if #(
    parameter int AD_W  = 12,
    parameter int CAR_W = 14,
    parameter int ACC_W = 36
) ();
    logic                    en;
    logic [1:0]              mode;
    logic [ACC_W-1:0]        ask_thresh;
    logic                    sym_sync;
    logic                    ad_valid;
    logic [AD_W-1:0]         ad_in;
    logic signed [CAR_W-1:0] car_cos;
    logic                    bit_out;
    logic                    bit_valid;
    logic signed [ACC_W-1:0] corr_out;
    logic                    busy;

    modport master (
        output en, mode, ask_thresh, sym_sync, ad_valid, ad_in, car_cos,
        input  bit_out, bit_valid, corr_out, busy
    );

    modport slave (
        input  en, mode, ask_thresh, sym_sync, ad_valid, ad_in, car_cos,
        output bit_out, bit_valid, corr_out, busy
    );
endinterface

// File: rtl/demod_2ask_bpsk_mac.sv
// Multiply stage and integrate-and-dump accumulator driven by first/last sample tags.
module mac_int_dump import demod_pkg::*; #(
    parameter int AD_W  = 12,
    parameter int CAR_W = 14,
    parameter int ACC_W = 36
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld_p0,
    input  logic                    first_p0,
    input  logic                    last_p0,
    input  logic                    drop,
    input  logic signed [AD_W-1:0]  smp_p0,
    input  logic signed [CAR_W-1:0] car_p0,
    output logic signed [ACC_W-1:0] acc_p2,
    output logic                    dump_p2
);
    localparam int PROD_W = prod_width(AD_W, CAR_W);

    logic signed [PROD_W-1:0] prod_p1;
    logic                     vld_p1;
    logic                     first_p1;
    logic                     last_p1;
    logic                     take_p1;

    // A completed symbol (last tag already in flight) survives a drop; partial ones do not.
    assign take_p1 = vld_p1 & ~(drop & ~last_p1);

    // P1: product and tags
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_p1  <= '0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            prod_p1  <= PROD_W'(smp_p0) * PROD_W'(car_p0);
            vld_p1   <= vld_p0;
            first_p1 <= vld_p0 & first_p0;
            last_p1  <= vld_p0 & last_p0;
        end
    end

    // P2: integrate, dump strobe follows the last-tagged sample
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p2  <= '0;
            dump_p2 <= 1'b0;
        end else begin
            dump_p2 <= take_p1 & last_p1;
            if (take_p1)
                acc_p2 <= first_p1 ? ACC_W'(prod_p1) : acc_p2 + ACC_W'(prod_p1);
        end
    end
endmodule

// File: rtl/demod_2ask_bpsk.sv
// Coherent integrate-and-dump demodulator: symbol framing FSM, MAC, and 2ASK/BPSK/2DPSK slicer.
module demod_2ask_bpsk import demod_pkg::*; #(
    parameter int AD_W    = 12,
    parameter int CAR_W   = 14,
    parameter int SYM_LEN = 500,
    parameter int ACC_W   = 36
) (
    input  logic             clk,
    input  logic             rst,
    demod_2ask_bpsk_if.slave bus
);
    localparam int CNT_W = clog2(SYM_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);

    if (ACC_W < AD_W + CAR_W + clog2(SYM_LEN)) begin : g_acc_w_chk
        $error("ACC_W too narrow for AD_W+CAR_W+clog2(SYM_LEN)");
    end

    function automatic logic signed [AD_W-1:0] to_signed(input logic [AD_W-1:0] raw);
        return signed'({~raw[AD_W-1], raw[AD_W-2:0]});
    endfunction

    // Extra bit keeps the magnitude of the most-negative value exact.
    function automatic logic [ACC_W:0] mag(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] w;
        w = {v[ACC_W-1], v};
        return v[ACC_W-1] ? unsigned'(-w) : unsigned'(w);
    endfunction

    function automatic logic slice(input logic [1:0] m, input logic signed [ACC_W-1:0] c,
                                   input logic [ACC_W-1:0] thr, input logic r);
        case (m)
            MODE_ASK:  return mag(c) > {1'b0, thr};
            MODE_DPSK: return c[ACC_W-1] ^ r;
            MODE_BPSK: return c[ACC_W-1];
            default:   return c[ACC_W-1];
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic [1:0]        sym_mode_q, mode_d, dump_mode_q;
    logic              ref_q;
    logic              start, accept, first, last, drop, ref_clr;
    logic signed [ACC_W-1:0] acc_p2;
    logic              dump_p2;
    logic              bit_out_p3, bit_valid_p3;
    logic signed [ACC_W-1:0] corr_p3;

    assign start = bus.ad_valid & (bus.sym_sync | armed_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        mode_d  = sym_mode_q;
        accept  = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        drop    = 1'b0;
        ref_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.en) begin
                    armed_d = 1'b0;
                end else if (start) begin
                    state_d = ST_INTEG;
                    accept  = 1'b1;
                    first   = 1'b1;
                    mode_d  = bus.mode;
                    cnt_d   = CNT_W'(1);
                    armed_d = 1'b0;
                end else if (bus.sym_sync) begin
                    armed_d = 1'b1;
                end
            end
            ST_INTEG: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                    drop    = 1'b1;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else if (bus.ad_valid) begin
                    accept  = 1'b1;
                    armed_d = 1'b0;
                    // Sync outranks the last-sample slot: a realign never dumps.
                    if (start || cnt_q == '0) begin
                        first  = 1'b1;
                        mode_d = bus.mode;
                        cnt_d  = CNT_W'(1);
                        if (start && cnt_q != '0) begin
                            drop    = 1'b1;
                            ref_clr = 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        last  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (bus.sym_sync) begin
                    armed_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            sym_mode_q  <= MODE_ASK;
            dump_mode_q <= MODE_ASK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            sym_mode_q <= mode_d;
            if (accept && last)
                dump_mode_q <= sym_mode_q;
        end
    end

    mac_int_dump #(.AD_W(AD_W), .CAR_W(CAR_W), .ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .vld_p0   (accept),
        .first_p0 (first),
        .last_p0  (last),
        .drop     (drop),
        .smp_p0   (to_signed(bus.ad_in)),
        .car_p0   (bus.car_cos),
        .acc_p2   (acc_p2),
        .dump_p2  (dump_p2)
    );

    // P3: decision registers and DPSK reference
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_out_p3   <= 1'b0;
            bit_valid_p3 <= 1'b0;
            corr_p3      <= '0;
            ref_q        <= 1'b0;
        end else begin
            bit_valid_p3 <= dump_p2;
            if (dump_p2) begin
                bit_out_p3 <= slice(dump_mode_q, acc_p2, bus.ask_thresh, ref_q);
                corr_p3    <= acc_p2;
                if (dump_mode_q == MODE_DPSK)
                    ref_q <= acc_p2[ACC_W-1];
            end
            if (ref_clr)
                ref_q <= 1'b0;
        end
    end

    assign bus.bit_out   = bit_out_p3;
    assign bus.bit_valid = bit_valid_p3;
    assign bus.corr_out  = corr_p3;
    assign bus.busy      = (state_q == ST_INTEG);
endmodule
